// File: rtl/tx_frame_queue_pkg.sv
// tx_frame_queue_pkg
// Shared definitions for the transmit framing queue: the FSM state encodings and
// the default FIFO depth.
// Optional feature macro: TX_FRAME_CHECKSUM_EN. When it is defined, the TXQ_CSUM
// state exists.
package tx_frame_queue_pkg;

    localparam int unsigned TXQ_DEFAULT_DEPTH = 8;

    typedef enum logic [2:0] {
        TXQ_IDLE    = 3'd0,
        TXQ_START   = 3'd1,
        TXQ_WAIT_HI = 3'd2,
        TXQ_WAIT_LO = 3'd3
`ifdef TX_FRAME_CHECKSUM_EN
        ,
        TXQ_CSUM    = 3'd4
`endif
    } txq_state_e;

endpackage

// File: rtl/tx_frame_queue_fifo.sv
// tx_fifo
// Parameterised synchronous FIFO that holds the {last, data} entries.
// It keeps the occupancy in a separate counter. Both pointers wrap modulo DEPTH,
// so DEPTH must be a power of two.
// Ports:
//   i_clk, i_reset    clock and asynchronous active-high reset
//   i_push, i_wdata   write strobe and entry; ignored when full
//   i_pop             read strobe; ignored when empty
//   o_rdata           head entry, read combinationally
//   o_full, o_empty   occupancy flags
//   o_count           current occupancy (0..DEPTH)
module tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 9
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage needs no reset; only the pointers and the count define validity.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/tx_frame_queue.sv
// tx_frame_queue
// Transmit framing queue. Producers push bytes, each tagged with an end-of-frame
// flag. The block hands the bytes one at a time to a UART transmitter through the
// TxD_start/TxD_busy handshake.
// Optional feature macro: TX_FRAME_CHECKSUM_EN. When it is defined, the block
// appends an XOR checksum byte after every frame.
// Ports:
//   i_clk, i_reset              clock and asynchronous active-high reset
//   i_wr_valid/data/last        producer byte and its end-of-frame flag
//   o_wr_ready                  FIFO not full
//   i_tx_busy                   transmitter busy (TxD_busy)
//   o_tx_start                  one-cycle start pulse (TxD_start)
//   o_tx_data                   byte presented to the transmitter
//   o_frame_done                pulse when the final byte of a frame completes
//   o_fill                      FIFO occupancy
//   o_overflow                  sticky write-while-full flag
module tx_frame_queue
    import tx_frame_queue_pkg::*;
#(
    parameter int unsigned DEPTH = TXQ_DEFAULT_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_wr_valid,
    input  logic [7:0]             i_wr_data,
    input  logic                   i_wr_last,
    output logic                   o_wr_ready,
    input  logic                   i_tx_busy,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_data,
    output logic                   o_frame_done,
    output logic [$clog2(DEPTH):0] o_fill,
    output logic                   o_overflow
);

    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [8:0]             w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_frame_end;

    txq_state_e r_state;
    txq_state_e w_state_next;

    logic       r_tx_start;
    logic [7:0] r_tx_data;
    logic       r_last;
    logic       r_frame_done;
    logic       r_overflow;
`ifdef TX_FRAME_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_csum_phase;
`endif

    assign w_push     = i_wr_valid && !w_full;
    assign o_wr_ready = !w_full;
    assign o_fill     = w_count;

    tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_wdata ({i_wr_last, i_wr_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= TXQ_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            TXQ_IDLE: begin
                // Hold off while the transmitter is still busy, so that a start
                // pulse never overlaps busy.
                if (!w_empty && !i_tx_busy) begin
                    w_pop        = 1'b1;
                    w_state_next = TXQ_START;
                end
            end
            TXQ_START: begin
                w_state_next = TXQ_WAIT_HI;
            end
            TXQ_WAIT_HI: begin
                if (i_tx_busy) begin
                    w_state_next = TXQ_WAIT_LO;
                end
            end
            TXQ_WAIT_LO: begin
                if (!i_tx_busy) begin
`ifdef TX_FRAME_CHECKSUM_EN
                    if (r_last) begin
                        w_state_next = TXQ_CSUM;
                    end else begin
                        w_frame_end  = r_csum_phase;
                        w_state_next = TXQ_IDLE;
                    end
`else
                    w_frame_end  = r_last;
                    w_state_next = TXQ_IDLE;
`endif
                end
            end
`ifdef TX_FRAME_CHECKSUM_EN
            TXQ_CSUM: begin
                w_state_next = TXQ_START;
            end
`endif
            default: begin
                w_state_next = TXQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
`ifdef TX_FRAME_CHECKSUM_EN
            r_csum       <= 8'h00;
            r_csum_phase <= 1'b0;
`endif
        end else begin
            // The start pulse is registered; it is high exactly while in START.
            r_tx_start   <= (w_state_next == TXQ_START);
            r_frame_done <= w_frame_end;
            if (i_wr_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_tx_data <= w_head[7:0];
                r_last    <= w_head[8];
            end
`ifdef TX_FRAME_CHECKSUM_EN
            if (w_pop) begin
                r_csum <= r_csum ^ w_head[7:0];
            end
            if (r_state == TXQ_CSUM) begin
                r_tx_data    <= r_csum;
                r_last       <= 1'b0;
                r_csum_phase <= 1'b1;
            end
            if (w_frame_end) begin
                r_csum       <= 8'h00;
                r_csum_phase <= 1'b0;
            end
`endif
        end
    end

    assign o_tx_start   = r_tx_start;
    assign o_tx_data    = r_tx_data;
    assign o_frame_done = r_frame_done;
    assign o_overflow   = r_overflow;

endmodule
